// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: chirp sequencer stepping the NCO from start to stop with dwell, clamp and hold.
// Define NCO_SWEEP_TRIANGLE_EN for an endless up/down sweep that bounces between both endpoints.
module nco_sweep_ctrl #(
  parameter int STEP_SIZE   = 16,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STEP_SIZE-1:0]   cfg_start_step,
  input  logic [STEP_SIZE-1:0]   cfg_stop_step,
  input  logic [STEP_SIZE-1:0]   cfg_delta,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic                   start,
  input  logic                   abort,
  output logic [STEP_SIZE-1:0]   step,
  output logic                   nco_rst,
  output logic                   busy,
  output logic                   done
);
  typedef enum logic [1:0] {IDLE, SWEEP, HOLD} state_t;
  state_t state, state_nx;
  logic [STEP_SIZE-1:0] start_s, stop_s, delta_s, start_s_nx, stop_s_nx, delta_s_nx, step_nx, nxt;
  logic [DWELL_WIDTH-1:0] dwell_s, dwell_s_nx, dwell_cnt, dwell_cnt_nx;
  logic dir_up, dir_up_nx, nco_rst_nx, busy_nx, done_nx, clamp;
  logic [STEP_SIZE:0] sum, diff;
  // One extra bit catches overflow on the way up and borrow on the way down.
  assign sum   = {1'b0, step} + {1'b0, delta_s};
  assign diff  = {1'b0, step} - {1'b0, delta_s};
  assign clamp = (delta_s == '0) || (dir_up ? (sum >= {1'b0, stop_s})
                                            : (diff[STEP_SIZE] || diff[STEP_SIZE-1:0] <= stop_s));
  assign nxt   = clamp ? stop_s : (dir_up ? sum[STEP_SIZE-1:0] : diff[STEP_SIZE-1:0]);
  always_comb begin
    state_nx     = state;
    start_s_nx   = start_s;
    stop_s_nx    = stop_s;
    delta_s_nx   = delta_s;
    dwell_s_nx   = dwell_s;
    dir_up_nx    = dir_up;
    dwell_cnt_nx = dwell_cnt;
    step_nx      = step;
    nco_rst_nx   = nco_rst;
    busy_nx      = busy;
    done_nx      = 1'b0;
    if (abort) begin
      state_nx     = IDLE;
      step_nx      = '0;
      nco_rst_nx   = 1'b1;
      busy_nx      = 1'b0;
      dwell_cnt_nx = '0;
    end else if (start && state != SWEEP) begin
      state_nx     = SWEEP;
      start_s_nx   = cfg_start_step;
      stop_s_nx    = cfg_stop_step;
      delta_s_nx   = cfg_delta;
      dwell_s_nx   = cfg_dwell;
      dir_up_nx    = cfg_stop_step >= cfg_start_step;
      dwell_cnt_nx = cfg_dwell;
      step_nx      = cfg_start_step;
      nco_rst_nx   = 1'b0;
      busy_nx      = 1'b1;
    end else if (state == SWEEP) begin
      if (dwell_cnt != '0) begin
        dwell_cnt_nx = dwell_cnt - 1'b1;
      end else if (nxt == stop_s) begin
        step_nx = stop_s;
        done_nx = 1'b1;
`ifdef NCO_SWEEP_TRIANGLE_EN
        dwell_cnt_nx = dwell_s;
        start_s_nx   = stop_s;
        stop_s_nx    = start_s;
        dir_up_nx    = ~dir_up;
`else
        busy_nx  = 1'b0;
        state_nx = HOLD;
`endif
      end else begin
        step_nx      = nxt;
        dwell_cnt_nx = dwell_s;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      start_s   <= '0;
      stop_s    <= '0;
      delta_s   <= '0;
      dwell_s   <= '0;
      dir_up    <= 1'b0;
      dwell_cnt <= '0;
      step      <= '0;
      nco_rst   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      start_s   <= start_s_nx;
      stop_s    <= stop_s_nx;
      delta_s   <= delta_s_nx;
      dwell_s   <= dwell_s_nx;
      dir_up    <= dir_up_nx;
      dwell_cnt <= dwell_cnt_nx;
      step      <= step_nx;
      nco_rst   <= nco_rst_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end
endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb_nco_sweep_ctrl: scoreboard bench; expected step/done/busy per output cycle queued, monitor compares.
module tb_nco_sweep_ctrl;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic [15:0] cfg_start_step = '0, cfg_stop_step = '0, cfg_delta = '0, cfg_dwell = '0;
  logic [15:0] step;
  logic nco_rst, busy, done;
  typedef struct packed {logic [15:0] s; logic d; logic b;} exp_t;
  exp_t q[$];
  exp_t e;
  int tests = 0, fails = 0;
  nco_sweep_ctrl dut (
    .clk(clk), .rst(rst), .cfg_start_step(cfg_start_step), .cfg_stop_step(cfg_stop_step),
    .cfg_delta(cfg_delta), .cfg_dwell(cfg_dwell), .start(start), .abort(abort),
    .step(step), .nco_rst(nco_rst), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rst && (busy || done)) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out step=%0d done=%0b busy=%0b", step, done, busy);
      end else begin
        e = q.pop_front();
        if (step !== e.s || done !== e.d || busy !== e.b) begin
          fails++;
          $display("FAIL seq got step=%0d done=%0b busy=%0b exp step=%0d done=%0b busy=%0b",
                   step, done, busy, e.s, e.d, e.b);
        end
      end
    end
  end
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask
  task automatic push(input logic [15:0] s, input int n, input logic d, input logic b);
    for (int i = 0; i < n; i++) q.push_back('{s: s, d: d, b: b});
  endtask
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_start(input logic [15:0] s, input logic [15:0] p, input logic [15:0] dl,
                          input logic [15:0] dw);
    @(posedge clk);
    #1;
    cfg_start_step = s; cfg_stop_step = p; cfg_delta = dl; cfg_dwell = dw; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask
  task automatic drain(input string name);
    for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL %s_timeout got=%0d pending exp=0", name, q.size());
      q.delete();
    end
    wait_cycles(3);
  endtask
  initial begin
    #12;
    check("rst_step", step, 0);
    check("rst_nco_rst", nco_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b1;
    wait_cycles(2);
`ifdef NCO_SWEEP_TRIANGLE_EN
    push(100, 3, 0, 1); push(110, 3, 0, 1); push(120, 3, 0, 1);
    push(130, 1, 1, 1); push(130, 2, 0, 1); push(120, 3, 0, 1); push(110, 3, 0, 1);
    push(100, 1, 1, 1); push(100, 2, 0, 1); push(110, 1, 0, 1);
    do_start(100, 130, 10, 2);
    wait_cycles(21);
    abort = 1'b1;
    wait_cycles(1);
    abort = 1'b0;
    check("tri_abort_step", step, 0);
    check("tri_abort_busy", busy, 0);
    drain("tri");
`else
    push(100, 3, 0, 1); push(110, 3, 0, 1); push(120, 3, 0, 1); push(130, 1, 1, 0);
    do_start(100, 130, 10, 2);
    drain("t1");
    check("hold_step", step, 130);
    check("hold_nco_rst", nco_rst, 0);
    check("hold_busy", busy, 0);
    push(100, 1, 0, 1); push(110, 1, 0, 1); push(120, 1, 0, 1); push(125, 1, 1, 0);
    do_start(100, 125, 10, 0);
    drain("t2_clamp");
    check("t2_hold_step", step, 125);
    push(200, 2, 0, 1); push(185, 2, 0, 1); push(170, 1, 1, 0);
    do_start(200, 170, 15, 1);
    drain("t3_down");
    push(16'h0010, 1, 0, 1); push(16'h0000, 1, 1, 0);
    do_start(16'h0010, 16'h0000, 16'h0020, 0);
    drain("t3_borrow");
    push(16'hFFF0, 1, 0, 1); push(16'hFFFF, 1, 1, 0);
    do_start(16'hFFF0, 16'hFFFF, 16'h0020, 0);
    drain("t4_wrap");
    push(5, 1, 0, 1); push(9, 1, 1, 0);
    do_start(5, 9, 0, 0);
    drain("t4_delta0");
    push(7, 2, 0, 1); push(7, 1, 1, 0);
    do_start(7, 7, 3, 1);
    drain("eq_endpoints");
    push(100, 3, 0, 1); push(110, 1, 0, 1);
    do_start(100, 130, 10, 2);
    wait_cycles(1);
    cfg_start_step = 500; cfg_stop_step = 900; start = 1'b1;
    wait_cycles(1);
    start = 1'b0;
    wait_cycles(1);
    abort = 1'b1;
    wait_cycles(1);
    abort = 1'b0;
    check("abort_step", step, 0);
    check("abort_nco_rst", nco_rst, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    drain("t5_abort");
    abort = 1'b1; start = 1'b1;
    wait_cycles(1);
    abort = 1'b0; start = 1'b0;
    check("abort_wins_busy", busy, 0);
    check("abort_wins_nco_rst", nco_rst, 1);
    push(100, 2, 0, 1);
    do_start(100, 130, 10, 2);
    wait_cycles(1);
    #5;
    rst = 1'b0;
    #1;
    check("async_rst_step", step, 0);
    check("async_rst_nco_rst", nco_rst, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    wait_cycles(2);
    rst = 1'b1;
    drain("t6_rst");
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
